// File: rtl/dma_read_scheduler.sv
// Round-robin scheduler sharing one DMA read engine among NUM_REQ requesters.
// Jobs are split into chunks of at most CHUNK_BYTES and issued through the engine's start/idle handshake.
module dma_read_scheduler #(
  parameter int unsigned NUM_REQ     = 3,
  parameter int unsigned CHUNK_BYTES = 4096
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*32-1:0] req_sa,
  input  logic [NUM_REQ*26-1:0] req_len,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    req_done,
  output logic [31:0]           dma_sa_config,
  output logic [25:0]           dma_length_config,
  output logic                  dma_read_valid,
  output logic                  dma_read_irq,
  input  logic                  dma_idle,
  output logic                  sched_busy,
  output logic [2:0]            grant_id
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_IDLE,
    NEXT,
    DONE
  } state_t;

  localparam logic [25:0] CHUNK    = 26'(CHUNK_BYTES);
  localparam logic [2:0]  LAST_RST = 3'(NUM_REQ - 1);

  state_t state, state_nx;

  logic [31:0] cur_addr, cur_addr_nx;
  logic [25:0] remaining, remaining_nx;
  logic [2:0]  last_grant, last_grant_nx;

  logic [NUM_REQ-1:0] req_ready_nx;
  logic [NUM_REQ-1:0] req_done_nx;
  logic [31:0]        sa_cfg_nx;
  logic [25:0]        len_cfg_nx;
  logic               read_valid_nx;
  logic               read_irq_nx;
  logic               busy_nx;
  logic [2:0]         grant_id_nx;

  // Round-robin search: first valid requester after last_grant, wrapping mod NUM_REQ
  logic [7:0] valid_pad;
  logic [3:0] cand;
  logic [2:0] win_idx;
  logic       win_found;

  assign valid_pad = 8'(req_valid);

  always_comb begin
    cand      = '0;
    win_idx   = '0;
    win_found = 1'b0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = {1'b0, last_grant} + 4'(i);
      if (cand >= 4'(NUM_REQ)) begin
        cand = cand - 4'(NUM_REQ);
      end
      if (!win_found && valid_pad[cand[2:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[2:0];
      end
    end
  end

  logic [31:0]        sel_sa;
  logic [25:0]        sel_len;
  logic [NUM_REQ-1:0] win_mask;
  logic [NUM_REQ-1:0] owner_mask;

  always_comb begin
    sel_sa     = '0;
    sel_len    = '0;
    win_mask   = '0;
    owner_mask = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      win_mask[i]   = (3'(i) == win_idx);
      owner_mask[i] = (3'(i) == grant_id);
      if (3'(i) == win_idx) begin
        sel_sa  = req_sa[i*32 +: 32];
        sel_len = req_len[i*26 +: 26];
      end
    end
  end

  logic [25:0] chunk_len;
  assign chunk_len = (remaining > CHUNK) ? CHUNK : remaining;

  always_comb begin
    state_nx      = state;
    cur_addr_nx   = cur_addr;
    remaining_nx  = remaining;
    last_grant_nx = last_grant;
    grant_id_nx   = grant_id;
    sa_cfg_nx     = dma_sa_config;
    len_cfg_nx    = dma_length_config;
    read_valid_nx = 1'b0;
    read_irq_nx   = 1'b0;
    req_ready_nx  = '0;
    req_done_nx   = '0;
    busy_nx       = sched_busy;

    case (state)
      IDLE: begin
        if (win_found && dma_idle) begin
          req_ready_nx  = win_mask;
          cur_addr_nx   = sel_sa;
          remaining_nx  = sel_len;
          grant_id_nx   = win_idx;
          last_grant_nx = win_idx;
          busy_nx       = 1'b1;
          state_nx      = ISSUE;
        end
      end
      ISSUE: begin
        // Zero-length jobs complete without touching the engine
        if (remaining == '0) begin
          state_nx = DONE;
        end else begin
          sa_cfg_nx     = cur_addr;
          len_cfg_nx    = chunk_len;
          read_valid_nx = 1'b1;
          state_nx      = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (!dma_idle) begin
          state_nx = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (dma_idle) begin
          state_nx = NEXT;
        end
      end
      NEXT: begin
        cur_addr_nx  = cur_addr + 32'(dma_length_config);
        remaining_nx = remaining - dma_length_config;
        if (remaining == dma_length_config) begin
          read_irq_nx = 1'b1;
          state_nx    = DONE;
        end else begin
          state_nx = ISSUE;
        end
      end
      DONE: begin
        req_done_nx = owner_mask;
        busy_nx     = 1'b0;
        state_nx    = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state             <= IDLE;
      cur_addr          <= '0;
      remaining         <= '0;
      last_grant        <= LAST_RST;
      grant_id          <= '0;
      dma_sa_config     <= '0;
      dma_length_config <= '0;
      dma_read_valid    <= 1'b0;
      dma_read_irq      <= 1'b0;
      req_ready         <= '0;
      req_done          <= '0;
      sched_busy        <= 1'b0;
    end else begin
      state             <= state_nx;
      cur_addr          <= cur_addr_nx;
      remaining         <= remaining_nx;
      last_grant        <= last_grant_nx;
      grant_id          <= grant_id_nx;
      dma_sa_config     <= sa_cfg_nx;
      dma_length_config <= len_cfg_nx;
      dma_read_valid    <= read_valid_nx;
      dma_read_irq      <= read_irq_nx;
      req_ready         <= req_ready_nx;
      req_done          <= req_done_nx;
      sched_busy        <= busy_nx;
    end
  end

endmodule
